// File: rtl/wide_to_narrow_fifo_feed_buffer.sv
// Purpose: width-down FIFO. It accepts DATA_W-bit words and returns DATA_R-bit elements, LSB element first, and can skip the rest of the head word.
// Latency: a popped element is on o_rddata/o_rdvalid one cycle after the accepted i_rden; a written word can be popped the cycle after its write.
// Backpressure: writes are dropped while o_full and pops are ignored while o_empty; the producer and consumer must respect both flags.
//
// Ports: system_clk/rst_n          clock and async active-low reset
//        i_wren/i_wrdata/o_full    word write side, plus o_almost_full
//        i_rden/o_rddata/o_rdvalid element read side, plus o_empty/o_almost_empty
//        skip_rest                 drop the unread elements of a partially read head word
module wide_to_narrow_fifo_feed_buffer #(
    parameter int DATA_W                 = 128,
    parameter int DEPTH_W                = 8,
    parameter int DATA_R                 = 8,
    parameter int DEPTH_R                = 12,
    parameter int ALMOST_FULL_THRESHOLD  = 2 ** (DEPTH_W - 1),
    parameter int ALMOST_EMPTY_THRESHOLD = 64
) (
    input  logic              system_clk,
    input  logic              rst_n,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_wrdata,
    output logic              o_full,
    output logic              o_almost_full,
    input  logic              i_rden,
    output logic [DATA_R-1:0] o_rddata,
    output logic              o_rdvalid,
    output logic              o_empty,
    output logic              o_almost_empty,
    input  logic              skip_rest
);
    // Elements per word. DATA_W must equal DATA_R * ELEMS.
    localparam int SUB   = DEPTH_R - DEPTH_W;
    localparam int ELEMS = 1 << SUB;

    localparam logic [DEPTH_W:0] WORD_CAP = (DEPTH_W + 1)'(1 << DEPTH_W);
    localparam logic [DEPTH_W:0] AF_TH    = (DEPTH_W + 1)'(ALMOST_FULL_THRESHOLD);
    localparam logic [DEPTH_R:0] AE_TH    = (DEPTH_R + 1)'(ALMOST_EMPTY_THRESHOLD);

    logic [DATA_W-1:0] mem [2 ** DEPTH_W];

    // Each pointer carries an extra wrap bit, so full and empty can be told apart.
    logic [DEPTH_W:0] wrptr;
    logic [DEPTH_R:0] rdptr;

    logic [DEPTH_W:0] word_cnt;
    logic [DEPTH_R:0] elem_cnt;
    logic [DEPTH_W:0] rd_word;
    logic [SUB-1:0]   rd_off;
    logic             wren;
    logic             rden;
    logic             skip_en;

    logic [ELEMS-1:0][DATA_R-1:0] head_elems;

    assign rd_word = rdptr[DEPTH_R:SUB];
    assign rd_off  = rdptr[SUB-1:0];

    // A partly read head word still counts as a full word of occupancy.
    // elem_cnt counts only committed words, so the word written in the current
    // cycle cannot be popped yet. That rules out a same-address read/write hazard.
    assign word_cnt = wrptr - rd_word;
    assign elem_cnt = {wrptr, {SUB{1'b0}}} - rdptr;

    assign o_full         = (word_cnt == WORD_CAP);
    assign o_empty        = (elem_cnt == '0);
    assign o_almost_full  = (word_cnt >= AF_TH);
    assign o_almost_empty = (elem_cnt < AE_TH);

    assign wren = i_wren & ~o_full;
    assign rden = i_rden & ~o_empty;
    // A pop takes priority over a skip issued in the same cycle. A skip at
    // offset 0 would throw away a whole unread word, so it does nothing.
    assign skip_en = skip_rest & ~rden & ~o_empty & (rd_off != '0);

    assign head_elems = mem[rd_word[DEPTH_W-1:0]];

    // The storage array has no reset; its contents do not matter until written.
    always_ff @(posedge system_clk) begin
        if (wren) begin
            mem[wrptr[DEPTH_W-1:0]] <= i_wrdata;
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            wrptr <= '0;
        end else if (wren) begin
            wrptr <= wrptr + 1'b1;
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            rdptr <= '0;
        end else if (rden) begin
            rdptr <= rdptr + 1'b1;
        end else if (skip_en) begin
            rdptr <= {rd_word + 1'b1, {SUB{1'b0}}};
        end
    end

    // o_rddata keeps its last value when no pop is accepted; only o_rdvalid drops.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rddata  <= '0;
            o_rdvalid <= 1'b0;
        end else begin
            o_rdvalid <= rden;
            if (rden) begin
                o_rddata <= head_elems[rd_off];
            end
        end
    end

endmodule

// File: tb/tb_wide_to_narrow_fifo_feed_buffer.sv
module tb_wide_to_narrow_fifo_feed_buffer;
    logic         system_clk = 1'b0;
    logic         rst_n      = 1'b0;
    logic         i_wren     = 1'b0;
    logic [127:0] i_wrdata   = '0;
    logic         i_rden     = 1'b0;
    logic         skip_rest  = 1'b0;
    logic         o_full, o_almost_full, o_rdvalid, o_empty, o_almost_empty;
    logic [7:0]   o_rddata;

    int errors = 0;
    int checks = 0;

    // Reference model. Stored words are kept in a queue, together with the
    // number of elements already consumed from the head word.
    logic [127:0] mq[$];
    int           head_off = 0;
    logic [7:0]   last_rd  = '0;

    wide_to_narrow_fifo_feed_buffer dut (
        .system_clk     (system_clk),
        .rst_n          (rst_n),
        .i_wren         (i_wren),
        .i_wrdata       (i_wrdata),
        .o_full         (o_full),
        .o_almost_full  (o_almost_full),
        .i_rden         (i_rden),
        .o_rddata       (o_rddata),
        .o_rdvalid      (o_rdvalid),
        .o_empty        (o_empty),
        .o_almost_empty (o_almost_empty),
        .skip_rest      (skip_rest)
    );

    always #5 system_clk = ~system_clk;

    function automatic int m_elems();
        return mq.size() * 16 - head_off;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_full"},   o_full,          mq.size() == 256);
        chk({tag, "_empty"},  o_empty,         m_elems() == 0);
        chk({tag, "_afull"},  o_almost_full,   mq.size() >= 128);
        chk({tag, "_aempty"}, o_almost_empty,  m_elems() < 64);
    endtask

    // Runs one clock cycle: drive the inputs, advance the model, then check the DUT.
    task automatic step(input bit wr, input logic [127:0] d, input bit rd, input bit sk, input string tag);
        bit         wacc, racc;
        logic [7:0] exp_b;
        @(negedge system_clk);
        i_wren = wr; i_wrdata = d; i_rden = rd; skip_rest = sk;
        wacc  = wr && (mq.size() < 256);
        racc  = rd && (m_elems() > 0);
        exp_b = last_rd;
        @(posedge system_clk);
        #1;
        if (racc) begin
            exp_b = mq[0][head_off*8 +: 8];
            head_off++;
            if (head_off == 16) begin
                void'(mq.pop_front());
                head_off = 0;
            end
        end else if (sk && mq.size() > 0 && head_off != 0) begin
            void'(mq.pop_front());
            head_off = 0;
        end
        if (wacc) mq.push_back(d);
        last_rd = exp_b;
        chk({tag, "_rdvalid"}, o_rdvalid, racc);
        chk({tag, "_rddata"},  o_rddata,  exp_b);
        chk_flags(tag);
    endtask

    function automatic logic [127:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] w0, wa, wb, wn;
        int           nwr, cyc;

        // Reset values, then pops into an empty FIFO.
        #3;
        chk("rst_empty",   o_empty,        1'b1);
        chk("rst_aempty",  o_almost_empty, 1'b1);
        chk("rst_full",    o_full,         1'b0);
        chk("rst_afull",   o_almost_full,  1'b0);
        chk("rst_rdvalid", o_rdvalid,      1'b0);
        chk("rst_rddata",  o_rddata,       8'h00);
        @(negedge system_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0, "empty_pop");

        // One word is read back LSB byte first.
        w0 = 128'h0F0E0D0C0B0A09080706050403020100;
        step(1, w0, 0, 0, "w0_write");
        for (int k = 0; k < 16; k++) begin
            step(0, '0, 1, 0, "w0_pop");
            chk("w0_byte", o_rddata, 8'(k));
        end
        chk("w0_empty_after", o_empty, 1'b1);

        // Fill to full; the 257th write is dropped. Full clears only when the head word is gone.
        for (int i = 0; i < 256; i++) step(1, rand_word(), 0, 0, "fill");
        chk("fill_full", o_full, 1'b1);
        step(1, rand_word(), 0, 0, "fill_drop");
        step(0, '0, 1, 0, "full_pop1");
        chk("full_after_1pop", o_full, 1'b1);
        for (int i = 0; i < 15; i++) step(0, '0, 1, 0, "full_pop15");
        chk("full_after_16pop", o_full, 1'b0);
        wn = mq[0];
        step(0, '0, 1, 0, "word1_b0");
        chk("word1_byte0", o_rddata, wn[7:0]);
        // Drain the rest by popping each head word once and skipping its remainder.
        cyc = 0;
        while (m_elems() > 0 && cyc < 2000) begin
            step(0, '0, 1, 0, "drain_pop");
            if (m_elems() > 0) step(0, '0, 0, 1, "drain_skip");
            cyc++;
        end
        chk("drain_done", o_empty, 1'b1);

        // skip_rest: mid-word skip, skip at offset 0, and skip together with a pop.
        wa = rand_word();
        wb = rand_word();
        step(1, wa, 0, 0, "skip_wa");
        step(1, wb, 0, 0, "skip_wb");
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0, "skip_pop3");
        chk("skip_a_byte2", o_rddata, wa[23:16]);
        step(0, '0, 0, 1, "skip_mid");
        step(0, '0, 0, 1, "skip_off0");
        step(0, '0, 1, 0, "skip_b0");
        chk("skip_b_byte0", o_rddata, wb[7:0]);
        step(0, '0, 1, 1, "skip_with_rd");
        chk("skip_rd_prio", o_rddata, wb[15:8]);
        step(0, '0, 1, 0, "skip_b2");
        chk("skip_b_byte2", o_rddata, wb[23:16]);
        while (m_elems() > 0) step(0, '0, 1, 0, "skip_drain");

        // Stream 1000 words with random gaps. The early phase leans toward writes so the FIFO fills past the almost-full threshold.
        nwr = 0;
        cyc = 0;
        while ((nwr < 1000 || m_elems() > 0) && cyc < 40000) begin
            bit wr, rd;
            wr = (nwr < 1000) && ($urandom_range(0, 99) < ((cyc < 3000) ? 90 : 30));
            rd = $urandom_range(0, 99) < ((cyc < 3000) ? 60 : 95);
            for (int k = 0; k < 16; k++) wn[k*8 +: 8] = 8'(nwr * 16 + k) ^ 8'(nwr >> 4);
            if (wr && mq.size() < 256) nwr++;
            step(wr, wn, rd, 1'b0, "stream");
            cyc++;
        end
        chk("stream_done", nwr == 1000 && m_elems() == 0, 1'b1);

        // Asynchronous reset arriving partway through the pops.
        for (int i = 0; i < 5; i++) step(1, rand_word(), 0, 0, "ar_fill");
        step(0, '0, 1, 0, "ar_pop");
        step(0, '0, 1, 0, "ar_pop");
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rdvalid", o_rdvalid,      1'b0);
        chk("ar_rddata",  o_rddata,       8'h00);
        chk("ar_empty",   o_empty,        1'b1);
        chk("ar_aempty",  o_almost_empty, 1'b1);
        chk("ar_full",    o_full,         1'b0);
        chk("ar_afull",   o_almost_full,  1'b0);
        mq.delete();
        head_off = 0;
        last_rd  = '0;
        @(negedge system_clk);
        i_wren = 1'b0; i_rden = 1'b0; skip_rest = 1'b0;
        @(negedge system_clk);
        rst_n = 1'b1;
        wn = rand_word();
        step(1, wn, 0, 0, "ar_new_write");
        for (int k = 0; k < 16; k++) begin
            step(0, '0, 1, 0, "ar_new_pop");
            chk("ar_new_byte", o_rddata, wn[k*8 +: 8]);
        end
        step(0, '0, 1, 0, "ar_after_empty");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
